// File: rtl/cmac_tx_arbiter_if.sv
// AXIS bundle for the CMAC TX arbiter: NUM_LANES parallel streams packed lane-major.
// The requester side uses NUM_LANES = NUM_PORTS, the CMAC side uses NUM_LANES = 1.
interface cmac_tx_arbiter_if #(
  parameter int unsigned NUM_LANES  = 1,
  parameter int unsigned DATA_WIDTH = 512
);
  logic [NUM_LANES*DATA_WIDTH-1:0]   tdata;
  logic [NUM_LANES*DATA_WIDTH/8-1:0] tkeep;
  logic [NUM_LANES-1:0]              tvalid;
  logic [NUM_LANES-1:0]              tready;
  logic [NUM_LANES-1:0]              tlast;
  logic [NUM_LANES-1:0]              tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cmac_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the single CMAC TX AXIS stream.
// A grant is held until the granted port's tlast beat is accepted; output is a registered slice.
module cmac_tx_arbiter #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned CMAC_DATA_WIDTH = 512,
  parameter int unsigned PTR_WIDTH       = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] port_en,
  cmac_tx_arbiter_if.slave     s_axis,
  cmac_tx_arbiter_if.master    m_axis,
  output logic [PTR_WIDTH-1:0] cur_grant,
  output logic                 busy,
  output logic [31:0]          pkt_cnt
);
  localparam int unsigned KeepW = CMAC_DATA_WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                     state_q, state_d;
  logic [PTR_WIDTH-1:0]       grant_q, grant_d;
  logic                       m_valid_q, m_valid_d;
  logic [CMAC_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KeepW-1:0]           m_keep_q, m_keep_d;
  logic                       m_last_q, m_last_d;
  logic                       m_user_q, m_user_d;
  logic [31:0]                pkt_cnt_q, pkt_cnt_d;

  logic [NUM_PORTS-1:0]       req;
  logic [NUM_PORTS-1:0]       s_ready;
  logic                       sel_valid, sel_last, sel_user;
  logic [CMAC_DATA_WIDTH-1:0] sel_data;
  logic [KeepW-1:0]           sel_keep;
  logic                       slot_free, accept, found;
  logic [PTR_WIDTH-1:0]       pick;

  // Mux the granted port's lane and generate per-port ready.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    s_ready   = '0;
    slot_free = !m_valid_q || m_axis.tready[0];
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == PTR_WIDTH'(i)) begin
        sel_valid  = s_axis.tvalid[i];
        sel_last   = s_axis.tlast[i];
        sel_user   = s_axis.tuser[i];
        sel_data   = s_axis.tdata[i*CMAC_DATA_WIDTH +: CMAC_DATA_WIDTH];
        sel_keep   = s_axis.tkeep[i*KeepW +: KeepW];
        s_ready[i] = (state_q == StBusy) && slot_free;
      end
    end
    accept = (state_q == StBusy) && sel_valid && slot_free;
  end

  // Rotating priority: first requester after the last grant wins.
  always_comb begin
    req   = s_axis.tvalid & port_en;
    pick  = grant_q;
    found = 1'b0;
    for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i] && (i == (32'(grant_q) + off) % NUM_PORTS)) begin
          pick  = PTR_WIDTH'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    pkt_cnt_d = pkt_cnt_q + 32'(m_valid_q && m_axis.tready[0] && m_last_q);

    if (m_axis.tready[0]) begin
      m_valid_d = 1'b0;
    end
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
      m_keep_d  = sel_keep;
      m_last_d  = sel_last;
      m_user_d  = sel_user;
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (accept && sel_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      grant_q   <= PTR_WIDTH'(NUM_PORTS - 1);
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tuser  = m_user_q;
  assign cur_grant     = grant_q;
  assign busy          = (state_q == StBusy);
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: doc/cmac_tx_arbiter.md
Name: cmac_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 512-bit CMAC TX AXIS stream between NUM_PORTS kernel requesters.
- Sits between the kernel traffic sources and the AXIS master toward cmac.
- Once a port is granted, the grant is locked until that port's tlast beat is accepted, so frames never interleave.
- Output is a registered slice; per-port enable comes from host-programmed control registers.

Parameters:
- NUM_PORTS, 2, number of requesting AXIS slave ports (2..8).
- CMAC_DATA_WIDTH, 512, tdata width; tkeep is CMAC_DATA_WIDTH/8.
- PTR_WIDTH, 3, grant index width; must satisfy 2^PTR_WIDTH >= NUM_PORTS.

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  synchronous, active-low reset.
- port_en  in  NUM_PORTS  per-port arbitration enable (host register).
- s_tdata  in  NUM_PORTS*CMAC_DATA_WIDTH  requester data; port i occupies slice i.
- s_tkeep  in  NUM_PORTS*CMAC_DATA_WIDTH/8  requester byte enables.
- s_tvalid  in  NUM_PORTS  requester valid.
- s_tready  out  NUM_PORTS  requester ready.
- s_tlast  in  NUM_PORTS  requester end of frame.
- s_tuser  in  NUM_PORTS  requester error/abort flag, passed through.
- m_tdata  out  CMAC_DATA_WIDTH  to cmac.
- m_tkeep  out  CMAC_DATA_WIDTH/8  to cmac.
- m_tvalid  out  1  to cmac.
- m_tready  in  1  from cmac.
- m_tlast  out  1  to cmac.
- m_tuser  out  1  to cmac.
- cur_grant  out  PTR_WIDTH  index of the currently or last granted port.
- busy  out  1  high while a frame is in progress (state BUSY).
- pkt_cnt  out  32  frames fully sent on m_* (m_tvalid & m_tready & m_tlast); wraps at 2^32.

Behaviour:
- Reset (rstn=0 at posedge clk):
  - state=IDLE, m_tvalid=0, s_tready=0, busy=0, cur_grant=NUM_PORTS-1 (so port 0 wins first), pkt_cnt=0.
  - m_tdata, m_tkeep, m_tlast and m_tuser are cleared to 0.
  - Reset mid-frame drops the in-flight beat and the rest of the frame. No recovery is attempted; the source must restart its frame.
- State machine (two states, IDLE and BUSY):
  - IDLE: req = s_tvalid & port_en. If req != 0, choose the first set bit searching cur_grant+1, cur_grant+2, ... modulo NUM_PORTS. Register it into cur_grant and go to BUSY. If req == 0, stay in IDLE.
  - BUSY: s_tready[cur_grant] = !m_tvalid | m_tready. All other s_tready bits are 0.
  - BUSY exit: on an accepted beat (s_tvalid[g] & s_tready[g]) with s_tlast[g]=1, go to IDLE on the next cycle.
  - In IDLE every s_tready bit is 0.
- Latency and throughput:
  - From s_tvalid rising in IDLE, the first beat is accepted 1 cycle later and appears on m_* 2 cycles after request.
  - Full throughput within a frame.
  - Exactly one idle cycle between consecutive frames (arbitration bubble).
- Output slice:
  - On an accepted beat, m_* load the granted slice and m_tvalid=1.
  - m_tvalid clears when m_tready=1 and no new beat is accepted that cycle.
  - m_* hold stable while m_tvalid=1 and m_tready=0 (AXIS rule).
- port_en:
  - Sampled only in IDLE.
  - Deasserting port_en for the granted port mid-frame has no effect until tlast.
  - port_en=0 for all ports keeps the block in IDLE; pending s_tvalid stay unserved.
- Source behaviour:
  - A source dropping s_tvalid mid-frame simply stalls; the grant is held indefinitely.
  - s_tuser is forwarded per beat and does not alter arbitration.
- Simultaneous events: pkt_cnt increments and a new beat loads in the same cycle without loss.

Test Plan:
- Reset, then port 0 sends a 4-beat frame with m_tready=1 -> m_tvalid high for exactly 4 consecutive cycles starting 2 cycles after s_tvalid; m_tlast on beat 4; pkt_cnt=1; cur_grant=0.
- Ports 0 and 1 both continuously request 3-beat frames -> output frame order 0,1,0,1; one idle cycle between frames; no beat interleaving; pkt_cnt=4 after 4 frames.
- m_tready toggles 1,0,0,1,... during a frame -> m_tdata/m_tkeep/m_tlast stable while stalled; no beat lost or duplicated; data matches source sequence.
- port_en=2'b10 with both ports requesting -> only port 1 served. Clearing port_en[1] mid-frame -> frame completes through tlast, then the block stays IDLE.
- Reset asserted on beat 2 of a 5-beat frame -> next cycle m_tvalid=0, s_tready=0, pkt_cnt=0, busy=0. After release, port 0 is granted first.
- Force pkt_cnt to 0xFFFFFFFF, send 1 frame -> pkt_cnt=0.
